// File: rtl/imem_responder_if.sv
// -----------------------------------------------------------------------------
// imem_responder_if
//   Bundles the fetch port and the program-loader port of imem_responder.
//   Parameters must match those of the imem_responder it is connected to.
//
//   Fetch (IF stage -> responder):
//     IF_Req, IF_Addr, IF_Flush
//   Fetch response (responder -> IF stage):
//     IMEM_Valid, IMEM_Instruction, IMEM_Busy
//   Loader (host -> responder):
//     Load_Start, Load_Base, Load_Count, Load_Byte_Valid, Load_Byte
//   Loader status (responder -> host):
//     Load_Byte_Ready, Load_Done, Load_Error
//
//   modport master : the side driving requests and load data
//   modport slave  : the instruction memory responder
// -----------------------------------------------------------------------------
interface imem_responder_if #(
  parameter int REG_DATA_WIDTH  = 32,
  parameter int IMEM_ADDR_WIDTH = 10
);

  // Fetch side
  logic                       IF_Req;
  logic [IMEM_ADDR_WIDTH-1:0] IF_Addr;
  logic                       IF_Flush;
  logic                       IMEM_Valid;
  logic [REG_DATA_WIDTH-1:0]  IMEM_Instruction;
  logic                       IMEM_Busy;

  // Loader side
  logic                       Load_Start;
  logic [IMEM_ADDR_WIDTH-1:0] Load_Base;
  logic [IMEM_ADDR_WIDTH:0]   Load_Count;
  logic                       Load_Byte_Valid;
  logic [7:0]                 Load_Byte;
  logic                       Load_Byte_Ready;
  logic                       Load_Done;
  logic                       Load_Error;

  modport master (
    output IF_Req, IF_Addr, IF_Flush,
    output Load_Start, Load_Base, Load_Count, Load_Byte_Valid, Load_Byte,
    input  IMEM_Valid, IMEM_Instruction, IMEM_Busy,
    input  Load_Byte_Ready, Load_Done, Load_Error
  );

  modport slave (
    input  IF_Req, IF_Addr, IF_Flush,
    input  Load_Start, Load_Base, Load_Count, Load_Byte_Valid, Load_Byte,
    output IMEM_Valid, IMEM_Instruction, IMEM_Busy,
    output Load_Byte_Ready, Load_Done, Load_Error
  );

endinterface

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Instruction memory with a one-cycle-latency, fully pipelined fetch port
//   and a byte-stream program loader.
//
//   The loader takes Load_Count words starting at word index Load_Base,
//   assembling each word little-endian from the byte stream (first byte into
//   bits [7:0]). The write pointer wraps modulo the memory depth. While the
//   loader is active (LOAD or DONE) IMEM_Busy is high and fetches are dropped.
//
//   Ports:
//     Clk   : sole clock, rising edge
//     Reset : asynchronous, active-high
//     bus   : imem_responder_if.slave (fetch + loader signals)
//
//   Outputs on bus:
//     IMEM_Valid / IMEM_Instruction : fetch response, zeroed when not valid
//                                     or when IF_Flush is high
//     IMEM_Busy       : loader active (LOAD or DONE)
//     Load_Byte_Ready : byte accepted this cycle when Load_Byte_Valid is high
//     Load_Done       : one-cycle pulse while in DONE
//     Load_Error      : one-cycle pulse after a rejected Load_Start
// -----------------------------------------------------------------------------
module imem_responder #(
  parameter int REG_DATA_WIDTH  = 32,
  parameter int IMEM_ADDR_WIDTH = 10,
  parameter int IMEM_DATA_DEPTH = 1024
) (
  input logic            Clk,
  input logic            Reset,
  imem_responder_if.slave bus
);

  localparam int BYTES_PER_WORD = REG_DATA_WIDTH / 8;
  localparam int BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [IMEM_ADDR_WIDTH:0]   DEPTH_C     = (IMEM_ADDR_WIDTH+1)'(IMEM_DATA_DEPTH);
  localparam logic [IMEM_ADDR_WIDTH:0]   ONE_WORD_C  = (IMEM_ADDR_WIDTH+1)'(1);
  localparam logic [IMEM_ADDR_WIDTH-1:0] PTR_INC_C   = IMEM_ADDR_WIDTH'(1);
  localparam logic [BCNT_W-1:0]          BCNT_INC_C  = BCNT_W'(1);
  localparam logic [BCNT_W-1:0]          BCNT_LAST_C = BCNT_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  // Loader state
  state_e                     state_q,    state_d;
  logic [IMEM_ADDR_WIDTH-1:0] ptr_q,      ptr_d;
  logic [IMEM_ADDR_WIDTH:0]   words_q,    words_d;
  logic [BCNT_W-1:0]          byte_cnt_q, byte_cnt_d;
  logic [REG_DATA_WIDTH-1:0]  word_q,     word_d;
  logic                       err_q,      err_d;

  // Fetch state
  logic                       valid_q,    valid_d;
  logic [REG_DATA_WIDTH-1:0]  rdata_q;

  logic [REG_DATA_WIDTH-1:0]  mem [IMEM_DATA_DEPTH];

  logic                       busy;
  logic                       start_ok;
  logic                       byte_xfer;
  logic                       last_byte;
  logic                       mem_we;
  logic                       fetch_ok;
  logic                       resp_valid;
  logic [REG_DATA_WIDTH-1:0]  word_merged;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  assign busy      = (state_q != IDLE);
  assign start_ok  = (bus.Load_Count != '0) && (bus.Load_Count <= DEPTH_C);
  assign byte_xfer = (state_q == LOAD) && bus.Load_Byte_Valid;
  assign last_byte = (byte_cnt_q == BCNT_LAST_C);
  assign fetch_ok  = bus.IF_Req && !busy;
  assign valid_d   = fetch_ok;

  // Current byte dropped into its little-endian lane of the partial word.
  always_comb begin
    word_merged = word_q;
    word_merged[{byte_cnt_q, 3'b000} +: 8] = bus.Load_Byte;
  end

  // ---------------------------------------------------------------------------
  // Loader FSM: next state and datapath updates
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement,
  // so no path through the block leaves a value unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    words_d    = words_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    err_d      = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Load_Start) begin
          if (start_ok) begin
            state_d    = LOAD;
            ptr_d      = bus.Load_Base;
            words_d    = bus.Load_Count;
            byte_cnt_d = '0;
            word_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (byte_xfer) begin
          if (last_byte) begin
            // Word complete: write it, advance the pointer (wraps naturally
            // because the depth is a power of two) and count it off.
            mem_we     = 1'b1;
            byte_cnt_d = '0;
            word_d     = '0;
            ptr_d      = ptr_q + PTR_INC_C;
            words_d    = words_q - ONE_WORD_C;
            if (words_q == ONE_WORD_C) begin
              state_d = DONE;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BCNT_INC_C;
            word_d     = word_merged;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      words_q    <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      words_q    <= words_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory array and read register
  // ---------------------------------------------------------------------------
  // NOTE: the array and its read register carry no reset: program contents
  // must survive Reset, and the read data is masked by valid_q (which is
  // reset) so a stale rdata_q never reaches the output.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[ptr_q] <= word_merged;
    end
    // Reading with a non-blocking assignment returns the pre-write word when
    // the same address is written on this edge.
    if (fetch_ok) begin
      rdata_q <= mem[bus.IF_Addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // IF_Flush squashes only the response currently on the outputs; a request
  // made in the same cycle was already captured by valid_q/rdata_q.
  assign resp_valid           = valid_q && !bus.IF_Flush;
  assign bus.IMEM_Valid       = resp_valid;
  assign bus.IMEM_Instruction = resp_valid ? rdata_q : '0;
  assign bus.IMEM_Busy        = busy;
  assign bus.Load_Byte_Ready  = (state_q == LOAD);
  assign bus.Load_Done        = (state_q == DONE);
  assign bus.Load_Error       = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//   Directed self-checking bench for imem_responder. Inputs change 1 time unit
//   after the rising edge; outputs are sampled at that same point (after
//   settling), away from the active edge.
// -----------------------------------------------------------------------------
module tb_imem_responder;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 1024;

  logic Clk;
  logic Reset;

  int checks;
  int errors;

  imem_responder_if #(.REG_DATA_WIDTH(DW), .IMEM_ADDR_WIDTH(AW)) bus ();

  imem_responder #(
    .REG_DATA_WIDTH (DW),
    .IMEM_ADDR_WIDTH(AW),
    .IMEM_DATA_DEPTH(DEPTH)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.Load_Byte_Valid = 1'b1;
    bus.Load_Byte       = b;
    step();
    bus.Load_Byte_Valid = 1'b0;
  endtask

  task automatic start_load(input logic [AW-1:0] base, input logic [AW:0] count);
    bus.Load_Start = 1'b1;
    bus.Load_Base  = base;
    bus.Load_Count = count;
    step();
    bus.Load_Start = 1'b0;
  endtask

  // Single fetch; response is checked in the following cycle.
  task automatic fetch_check(input string tag, input logic [AW-1:0] addr, input logic [31:0] exp);
    bus.IF_Req  = 1'b1;
    bus.IF_Addr = addr;
    step();
    bus.IF_Req  = 1'b0;
    check({tag, "_valid"}, 32'(bus.IMEM_Valid), 32'd1);
    check({tag, "_instr"}, bus.IMEM_Instruction, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    Reset               = 1'b1;
    bus.IF_Req          = 1'b0;
    bus.IF_Addr         = '0;
    bus.IF_Flush        = 1'b0;
    bus.Load_Start      = 1'b0;
    bus.Load_Base       = '0;
    bus.Load_Count      = '0;
    bus.Load_Byte_Valid = 1'b0;
    bus.Load_Byte       = '0;

    // ---- Reset state ----
    step();
    step();
    check("rst_valid", 32'(bus.IMEM_Valid),      32'd0);
    check("rst_instr", bus.IMEM_Instruction,     32'd0);
    check("rst_busy",  32'(bus.IMEM_Busy),       32'd0);
    check("rst_ready", 32'(bus.Load_Byte_Ready), 32'd0);
    check("rst_done",  32'(bus.Load_Done),       32'd0);
    check("rst_error", 32'(bus.Load_Error),      32'd0);
    Reset = 1'b0;
    step();

    // ---- Load 2 words at 0x004 ----
    start_load(10'h004, 11'd2);
    check("ld_busy",  32'(bus.IMEM_Busy),       32'd1);
    check("ld_ready", 32'(bus.Load_Byte_Ready), 32'd1);
    // Load_Start during LOAD with an illegal count must be ignored silently.
    bus.Load_Start = 1'b1;
    bus.Load_Count = 11'd0;
    send_byte(8'h13);
    bus.Load_Start = 1'b0;
    check("ld_ignore_start_err", 32'(bus.Load_Error), 32'd0);
    send_byte(8'h00);
    step();                                   // idle gap: no byte transferred
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h93);
    send_byte(8'h00);
    send_byte(8'h10);
    check("ld_not_done_yet", 32'(bus.Load_Done), 32'd0);
    send_byte(8'h00);
    check("ld_done",      32'(bus.Load_Done),       32'd1);
    check("ld_done_busy", 32'(bus.IMEM_Busy),       32'd1);
    check("ld_done_rdy",  32'(bus.Load_Byte_Ready), 32'd0);
    step();
    check("ld_done_pulse", 32'(bus.Load_Done), 32'd0);
    check("ld_idle_busy",  32'(bus.IMEM_Busy), 32'd0);

    // ---- Back-to-back fetch of 4 then 5 ----
    bus.IF_Req  = 1'b1;
    bus.IF_Addr = 10'h004;
    step();
    bus.IF_Addr = 10'h005;
    check("b2b0_valid", 32'(bus.IMEM_Valid), 32'd1);
    check("b2b0_instr", bus.IMEM_Instruction, 32'h0000_0013);
    step();
    bus.IF_Req = 1'b0;
    check("b2b1_valid", 32'(bus.IMEM_Valid), 32'd1);
    check("b2b1_instr", bus.IMEM_Instruction, 32'h0010_0093);
    step();
    check("b2b_end_valid", 32'(bus.IMEM_Valid), 32'd0);
    check("b2b_end_instr", bus.IMEM_Instruction, 32'd0);

    // ---- Rejected loads: count 0 and count 1025 ----
    start_load(10'h004, 11'd0);
    check("err0_pulse", 32'(bus.Load_Error), 32'd1);
    check("err0_busy",  32'(bus.IMEM_Busy),  32'd0);
    step();
    check("err0_clear", 32'(bus.Load_Error), 32'd0);
    start_load(10'h004, 11'd1025);
    check("err1025_pulse", 32'(bus.Load_Error), 32'd1);
    check("err1025_busy",  32'(bus.IMEM_Busy),  32'd0);
    step();
    check("err1025_clear", 32'(bus.Load_Error), 32'd0);
    check("err1025_busy2", 32'(bus.IMEM_Busy),  32'd0);
    fetch_check("err_mem4", 10'h004, 32'h0000_0013);
    fetch_check("err_mem5", 10'h005, 32'h0010_0093);

    // ---- Wrapping load at 0x3FF ----
    start_load(10'h3FF, 11'd2);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    send_byte(8'h88); send_byte(8'h77); send_byte(8'h66); send_byte(8'h55);
    check("wrap_done", 32'(bus.Load_Done), 32'd1);
    step();
    fetch_check("wrap_3ff", 10'h3FF, 32'h1122_3344);
    fetch_check("wrap_000", 10'h000, 32'h5566_7788);

    // ---- Flush squashes the presented response, not a new request ----
    bus.IF_Req  = 1'b1;
    bus.IF_Addr = 10'h004;
    step();
    bus.IF_Addr  = 10'h005;
    bus.IF_Flush = 1'b1;
    #1;
    check("flush_valid", 32'(bus.IMEM_Valid), 32'd0);
    check("flush_instr", bus.IMEM_Instruction, 32'd0);
    step();
    bus.IF_Flush = 1'b0;
    bus.IF_Req   = 1'b0;
    #1;
    check("post_flush_valid", 32'(bus.IMEM_Valid), 32'd1);
    check("post_flush_instr", bus.IMEM_Instruction, 32'h0010_0093);
    step();

    // ---- Reset during a 3-word load after 6 bytes; fetch while busy ----
    start_load(10'h008, 11'd3);
    bus.IF_Req  = 1'b1;
    bus.IF_Addr = 10'h004;
    send_byte(8'hAA);
    bus.IF_Req = 1'b0;
    check("busy_drop_valid", 32'(bus.IMEM_Valid), 32'd0);
    check("busy_drop_instr", bus.IMEM_Instruction, 32'd0);
    send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h01); send_byte(8'h02);
    Reset = 1'b1;
    #1;
    check("abort_busy",  32'(bus.IMEM_Busy),       32'd0);
    check("abort_ready", 32'(bus.Load_Byte_Ready), 32'd0);
    check("abort_done",  32'(bus.Load_Done),       32'd0);
    step();
    Reset = 1'b0;
    step();
    check("abort_idle_busy", 32'(bus.IMEM_Busy), 32'd0);
    fetch_check("abort_mem8", 10'h008, 32'hDDCC_BBAA);
    fetch_check("abort_mem4", 10'h004, 32'h0000_0013);

    // A fresh single-word load after the abort starts from a clean byte lane.
    start_load(10'h009, 11'd1);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check("reload_done", 32'(bus.Load_Done), 32'd1);
    step();
    fetch_check("reload_mem9", 10'h009, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
